// File: rtl/result_stream_reader_pkg.sv
// Shared defaults and reader FSM state encoding for the result BRAM drain engine.
package result_stream_reader_pkg;

  localparam int PE_COUNT_DEF   = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BRAM_DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO holding BRAM read data plus its last-row tag; head drives the stream.
module result_skid_fifo #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/result_stream_reader.sv
// Drains a contiguous range of result BRAM rows onto an AXI4-Stream master, one row per beat.
module result_stream_reader
  import result_stream_reader_pkg::*;
#(
  parameter int PE_COUNT   = PE_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int BEAT_WIDTH = PE_COUNT * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_r_en,
  output logic [ADDR_WIDTH-1:0] bram_r_addr,
  input  logic [BEAT_WIDTH-1:0] bram_r_rdata,
  output logic [BEAT_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(BRAM_DEPTH - 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [1:0]            fifo_count;
  logic [BEAT_WIDTH:0]   fifo_head;
  logic [2:0]            occ;
  logic                  pop;
  logic                  issue;
  logic                  issue_last;

  assign m_axis_tvalid = (fifo_count != 2'd0);
  assign m_axis_tdata  = fifo_head[BEAT_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & fifo_head[BEAT_WIDTH];
  assign pop           = m_axis_tvalid & m_axis_tready;

  // Occupancy the FIFO will have after this edge, counting the read already in flight.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == RD_RUN) && (occ < 3'd2);
  assign issue_last = issue && (issued_q == (len_q - LEN_ONE));

  assign bram_r_en   = issue;
  assign bram_r_addr = issue ? rd_ptr_q : addr_q;
  assign busy        = (state_q != RD_IDLE);
  assign done        = (state_q == RD_DONE);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    case (state_q)
      RD_IDLE: begin
        if (start) begin
          len_d    = length;
          rd_ptr_d = base_addr;
          issued_d = '0;
          state_d  = (length == LEN_ZERO) ? RD_DONE : RD_RUN;
        end
      end
      RD_RUN: begin
        if (issue) begin
          issued_d = issued_q + LEN_ONE;
          addr_d   = rd_ptr_q;
          rd_ptr_d = (rd_ptr_q == ADDR_MAX) ? '0 : (rd_ptr_q + ADDR_ONE);
          if (issue_last) begin
            state_d = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (pop && fifo_head[BEAT_WIDTH]) begin
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= RD_IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      rd_ptr_q        <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      rd_ptr_q        <= rd_ptr_d;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

  result_skid_fifo #(
    .W(BEAT_WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (inflight_q),
    .din_i  ({inflight_last_q, bram_r_rdata}),
    .pop_i  (pop),
    .count_o(fifo_count),
    .head_o (fifo_head)
  );

endmodule

// File: tb/tb_result_stream_reader.sv
// Randomized and directed bench for result_stream_reader against a queue-based transfer model.
module tb_result_stream_reader;

  localparam int AW    = 10;
  localparam int BW    = 128;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, bram_r_en;
  logic [AW-1:0] bram_r_addr;
  logic [BW-1:0] bram_r_rdata = '0;
  logic [BW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;

  always #5 clk = ~clk;

  result_stream_reader dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .bram_r_en    (bram_r_en),
    .bram_r_addr  (bram_r_addr),
    .bram_r_rdata (bram_r_rdata),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  logic [BW-1:0] mem [DEPTH];
  always @(posedge clk) if (bram_r_en) bram_r_rdata <= mem[bram_r_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mode = 0;
  int pat  = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0: m_axis_tready = 1'b1;
      1: begin m_axis_tready = (pat % 3 == 0); pat++; end
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Transfer model: what must be read and streamed for each accepted start.
  bit            active = 0;
  int            start_cyc = 0;
  int            exp_done = -1;
  int            exp_addr[$];
  logic [BW:0]   exp_beat[$];
  bit            prev_stall = 0;
  logic [BW:0]   prev_beat = '0;
  int            hs_count = 0;
  int            en_cnt = 0;
  int            done_cyc = -1;
  int            tv_cyc[$];
  int            tlast_cyc[$];
  int            addr_log[$];
  logic [31:0]   hs_lane[$];

  always @(negedge clk) begin
    automatic bit          was_active = active;
    automatic logic [BW:0] eb;
    automatic int          a;
    automatic int          len;
    automatic int          row;
    if (!rstn) begin
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en", bram_r_en, 0);
      exp_addr.delete();
      exp_beat.delete();
      active     = 0;
      exp_done   = -1;
      prev_stall = 0;
    end else begin
      check("fifo_count_le2", dut.u_fifo.count_o <= 2'd2, 1);
      check("busy", busy, active && (cyc > start_cyc));
      check("done", done, active && (cyc == exp_done));
      if (done) done_cyc = cyc;
      if (active && cyc == exp_done) active = 0;
      if (bram_r_en) begin
        en_cnt++;
        addr_log.push_back(int'(bram_r_addr));
        if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
        else begin
          a = exp_addr.pop_front();
          check("rd_addr", bram_r_addr, a);
        end
      end
      if (m_axis_tvalid) tv_cyc.push_back(cyc);
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_count++;
        hs_lane.push_back(m_axis_tdata[31:0]);
        if (m_axis_tlast) tlast_cyc.push_back(cyc);
        if (exp_beat.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          eb = exp_beat.pop_front();
          check("beat", {m_axis_tlast, m_axis_tdata}, eb);
          if (eb[BW]) exp_done = cyc + 1;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
      if (start && !was_active) begin
        active    = 1;
        start_cyc = cyc;
        len       = int'(length);
        hs_count  = 0;
        en_cnt    = 0;
        done_cyc  = -1;
        tv_cyc.delete();
        tlast_cyc.delete();
        addr_log.delete();
        hs_lane.delete();
        for (int i = 0; i < len; i++) begin
          row = (int'(base_addr) + i) % DEPTH;
          exp_addr.push_back(row);
          exp_beat.push_back({(i == len - 1), mem[row]});
        end
        exp_done = (len == 0) ? cyc + 1 : -1;
      end
    end
  end

  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW + 1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && active; i++) begin
      @(negedge clk); #1;
    end
    check("timeout_idle", active, 0);
    @(negedge clk); #1;
  endtask

  initial begin
    automatic int n;
    automatic int b;
    for (int r = 0; r < DEPTH; r++)
      mem[r] = {$urandom, $urandom, $urandom, 32'h0000_00A0 + 32'(r)};

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", bram_r_addr, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    rstn = 1'b1;

    // Basic transfer, tready held high.
    mode = 0;
    do_start(0, 4);
    wait_idle(100);
    check("t1_nbeats", tv_cyc.size(), 4);
    check("t1_first_tvalid", tv_cyc[0], start_cyc + 3);
    check("t1_last_tvalid", tv_cyc[3], start_cyc + 6);
    check("t1_lane_row0", hs_lane[0], 32'hA0);
    check("t1_lane_row3", hs_lane[3], 32'hA3);
    check("t1_ntlast", tlast_cyc.size(), 1);
    check("t1_tlast_cyc", tlast_cyc[0], start_cyc + 6);
    check("t1_done_cyc", done_cyc, start_cyc + 7);

    // Address wrap at the top of the BRAM.
    do_start(1022, 4);
    wait_idle(100);
    check("t2_addr0", addr_log[0], 1022);
    check("t2_addr1", addr_log[1], 1023);
    check("t2_addr2", addr_log[2], 0);
    check("t2_addr3", addr_log[3], 1);
    check("t2_last_lane", hs_lane[3], 32'hA1);

    // Backpressure patterns.
    mode = 1;
    do_start(37, 8);
    wait_idle(200);
    check("t3_hs_count", hs_count, 8);
    mode = 2;
    do_start(900, 8);
    wait_idle(200);
    check("t3r_hs_count", hs_count, 8);

    // Zero-length request.
    mode = 0;
    do_start(5, 0);
    wait_idle(20);
    check("t4_no_reads", en_cnt, 0);
    check("t4_no_beats", tv_cyc.size(), 0);
    check("t4_done_cyc", done_cyc, start_cyc + 1);

    // Start while busy is ignored.
    do_start(10, 20);
    repeat (4) @(negedge clk);
    do_start(500, 3);
    wait_idle(200);
    check("t5_hs_count", hs_count, 20);

    // Reset in the middle of a stalled transfer.
    do_start(200, 16);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (hs_count >= 2) break;
    end
    check("t6_reached_beat3", hs_count, 2);
    mode = 3;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    mode = 0;
    do_start(300, 16);
    wait_idle(200);
    check("t6_hs_count", hs_count, 16);

    // Random transfers with random backpressure.
    for (int k = 0; k < 6; k++) begin
      mode = 2;
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 40);
      do_start(b, n);
      wait_idle(2000);
      check("rand_hs_count", hs_count, n);
    end

    // Full-depth transfer.
    mode = 0;
    do_start(700, DEPTH);
    wait_idle(3000);
    check("full_hs_count", hs_count, DEPTH);
    check("full_last_addr", addr_log[DEPTH-1], 699);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
